// File: rtl/ka_overlap_accum.sv
// Karatsuba overlap accumulator: XOR-combines the low/middle/high partial
// products of an N-bit carry-less Karatsuba step into a (2N-1)-bit result.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             sync clear of the partial accumulation
//   pp_valid/pp_ready partial-product stream handshake
//   pp_sel            0 = low (<<0), 1 = middle (<<H), 2 = high (<<N)
//   pp_data           (N-1)-bit partial product
//   out_valid/ready   registered result handshake
//   out_data          (2N-1)-bit combined product
//   pp_err            one-cycle pulse per discarded illegal/duplicate beat
module ka_overlap_accum #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           pp_valid,
    output logic           pp_ready,
    input  logic [1:0]     pp_sel,
    input  logic [N-2:0]   pp_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] out_data,
    output logic           pp_err
);

    localparam int H = N / 2;
    localparam int W = 2 * N - 1;

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] out_q, out_d;
    logic [2:0]   got_q, got_d;
    logic         ov_q, ov_d;
    logic         err_q, err_d;

    logic [W-1:0] pp_ext;
    logic [W-1:0] pp_sh;
    logic [2:0]   sel_oh;
    logic         two_got;
    logic         stalled;
    logic         accept;
    logic         legal;

    assign pp_ext = {{N{1'b0}}, pp_data};

    always_comb begin
        pp_sh  = '0;
        sel_oh = '0;
        unique case (pp_sel)
            2'd0: begin
                pp_sh  = pp_ext;
                sel_oh = 3'b001;
            end
            2'd1: begin
                pp_sh  = pp_ext << H;
                sel_oh = 3'b010;
            end
            2'd2: begin
                pp_sh  = pp_ext << N;
                sel_oh = 3'b100;
            end
            default: begin
                pp_sh  = '0;
                sel_oh = '0;
            end
        endcase
    end

    // The next legal beat completes the product exactly when two of the
    // three slots are already filled.
    assign two_got = (got_q == 3'b011) || (got_q == 3'b101)
                  || (got_q == 3'b110);

    // Only a completing beat needs the output register, so partial beats
    // keep flowing while the output is stalled.
    assign stalled  = ov_q && !out_ready;
    assign pp_ready = !stalled || !two_got;

    assign accept = pp_valid && pp_ready;
    assign legal  = (|sel_oh) && !(|(got_q & sel_oh));

    always_comb begin
        acc_d = acc_q;
        got_d = got_q;
        out_d = out_q;
        ov_d  = ov_q;
        err_d = 1'b0;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (flush) begin
            acc_d = '0;
            got_d = '0;
        end else if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end else if (two_got) begin
                out_d = acc_q ^ pp_sh;
                ov_d  = 1'b1;
                acc_d = '0;
                got_d = '0;
            end else begin
                acc_d = acc_q ^ pp_sh;
                got_d = got_q | sel_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            got_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            got_q <= got_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            err_q <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = out_q;
    assign pp_err    = err_q;

endmodule

// File: tb/tb_ka_overlap_accum.sv
// Directed and randomised bench for ka_overlap_accum at N=8 and N=32.
// Each scenario task drives stimulus and checks results inline.
module tb_ka_overlap_accum;

    logic clk;
    logic rst_n;

    logic        flush8, pv8, pr8, ov8, or8, err8;
    logic [1:0]  sel8;
    logic [6:0]  dat8;
    logic [14:0] od8;

    logic        flush32, pv32, pr32, ov32, or32, err32;
    logic [1:0]  sel32;
    logic [30:0] dat32;
    logic [62:0] od32;

    int vectors;
    int miscompares;

    localparam int BUDGET = 80000;

    ka_overlap_accum #(.N(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush8),
        .pp_valid  (pv8),
        .pp_ready  (pr8),
        .pp_sel    (sel8),
        .pp_data   (dat8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8),
        .pp_err    (err8)
    );

    ka_overlap_accum #(.N(32)) u32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush32),
        .pp_valid  (pv32),
        .pp_ready  (pr32),
        .pp_sel    (sel32),
        .pp_data   (dat32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_data  (od32),
        .pp_err    (err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic [1:0] s, input logic [6:0] d,
                         output logic rdy);
        pv8  = 1'b1;
        sel8 = s;
        dat8 = d;
        #1;
        rdy = pr8;
        @(posedge clk);
        #1;
        pv8 = 1'b0;
    endtask

    task automatic beat32(input logic [1:0] s, input logic [30:0] d);
        pv32  = 1'b1;
        sel32 = s;
        dat32 = d;
        @(posedge clk);
        #1;
        pv32 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush8 = 0; pv8 = 0; sel8 = 0; dat8 = 0; or8 = 1;
        flush32 = 0; pv32 = 0; sel32 = 0; dat32 = 0; or32 = 1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (ov8 !== 1'b0 || od8 !== 15'h0 || err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b d=%h e=%b want 0 0 0",
                     ov8, od8, err8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (pr8 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", pr8);
        end
    endtask

    task automatic test_basic;
        logic r;
        or8 = 1'b1;
        beat8(2'd0, 7'h7F, r);
        beat8(2'd1, 7'h7F, r);
        beat8(2'd2, 7'h7F, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h788F) begin
            miscompares++;
            $display("FAIL basic: got v=%b d=%h want 1 788f", ov8, od8);
        end
        step();
        vectors++;
        if (ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse: got v=%b want 0", ov8);
        end
    endtask

    task automatic test_back_to_back;
        logic r;
        logic allr;
        allr = 1'b1;
        or8 = 1'b1;
        beat8(2'd2, 7'h7F, r); allr &= r;
        beat8(2'd0, 7'h00, r); allr &= r;
        beat8(2'd1, 7'h00, r); allr &= r;
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h7F00) begin
            miscompares++;
            $display("FAIL b2b_first: got v=%b d=%h want 1 7f00", ov8, od8);
        end
        beat8(2'd1, 7'h7F, r); allr &= r;
        beat8(2'd2, 7'h00, r); allr &= r;
        beat8(2'd0, 7'h00, r); allr &= r;
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h07F0) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b d=%h want 1 07f0", ov8, od8);
        end
        vectors++;
        if (allr !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b want 1", allr);
        end
        step();
    endtask

    task automatic test_duplicate;
        logic r;
        or8 = 1'b1;
        beat8(2'd0, 7'h01, r);
        beat8(2'd0, 7'h02, r);
        vectors++;
        if (err8 !== 1'b1) begin
            miscompares++;
            $display("FAIL dup_err: got %b want 1", err8);
        end
        beat8(2'd1, 7'h00, r);
        vectors++;
        if (err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL dup_err_pulse: got %b want 0", err8);
        end
        beat8(2'd2, 7'h00, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0001) begin
            miscompares++;
            $display("FAIL dup_result: got v=%b d=%h want 1 0001", ov8, od8);
        end
        beat8(2'd3, 7'h7F, r);
        vectors++;
        if (err8 !== 1'b1) begin
            miscompares++;
            $display("FAIL sel3_err: got %b want 1", err8);
        end
        beat8(2'd0, 7'h05, r);
        beat8(2'd1, 7'h00, r);
        vectors++;
        if (ov8 !== 1'b0 || err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL sel3_nostate: got v=%b e=%b want 0 0", ov8, err8);
        end
        beat8(2'd2, 7'h00, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0005) begin
            miscompares++;
            $display("FAIL sel3_result: got v=%b d=%h want 1 0005", ov8, od8);
        end
        step();
    endtask

    task automatic test_stall;
        logic r;
        or8 = 1'b0;
        beat8(2'd0, 7'h03, r);
        beat8(2'd1, 7'h00, r);
        beat8(2'd2, 7'h00, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0003) begin
            miscompares++;
            $display("FAIL stall_first: got v=%b d=%h want 1 0003", ov8, od8);
        end
        beat8(2'd0, 7'h10, r);
        vectors++;
        if (r !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_beat1_ready: got %b want 1", r);
        end
        beat8(2'd1, 7'h02, r);
        vectors++;
        if (r !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_beat2_ready: got %b want 1", r);
        end
        pv8 = 1'b1; sel8 = 2'd2; dat8 = 7'h01;
        #1;
        vectors++;
        if (pr8 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_block: got %b want 0", pr8);
        end
        step();
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0003 || pr8 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b d=%h r=%b want 1 0003 0",
                     ov8, od8, pr8);
        end
        or8 = 1'b1;
        #1;
        vectors++;
        if (pr8 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got %b want 1", pr8);
        end
        step();
        pv8 = 1'b0;
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0130) begin
            miscompares++;
            $display("FAIL stall_swap: got v=%b d=%h want 1 0130", ov8, od8);
        end
        step();
        vectors++;
        if (ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: got v=%b want 0", ov8);
        end
    endtask

    task automatic test_flush;
        logic r;
        or8 = 1'b1;
        beat8(2'd0, 7'h7F, r);
        beat8(2'd1, 7'h7F, r);
        flush8 = 1'b1;
        pv8 = 1'b1; sel8 = 2'd2; dat8 = 7'h7F;
        step();
        flush8 = 1'b0; pv8 = 1'b0;
        vectors++;
        if (ov8 !== 1'b0 || err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got v=%b e=%b want 0 0", ov8, err8);
        end
        flush8 = 1'b1;
        pv8 = 1'b1; sel8 = 2'd3; dat8 = 7'h00;
        step();
        flush8 = 1'b0; pv8 = 1'b0;
        vectors++;
        if (err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_err_prio: got %b want 0", err8);
        end
        beat8(2'd0, 7'h11, r);
        beat8(2'd1, 7'h00, r);
        beat8(2'd2, 7'h00, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0011) begin
            miscompares++;
            $display("FAIL flush_result: got v=%b d=%h want 1 0011", ov8, od8);
        end
        or8 = 1'b0;
        beat8(2'd0, 7'h40, r);
        flush8 = 1'b1;
        step();
        flush8 = 1'b0;
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0011) begin
            miscompares++;
            $display("FAIL flush_keep_out: got v=%b d=%h want 1 0011",
                     ov8, od8);
        end
        or8 = 1'b1;
        beat8(2'd1, 7'h00, r);
        beat8(2'd2, 7'h00, r);
        beat8(2'd0, 7'h01, r);
        vectors++;
        if (ov8 !== 1'b1 || od8 !== 15'h0001) begin
            miscompares++;
            $display("FAIL flush_clear: got v=%b d=%h want 1 0001", ov8, od8);
        end
        step();
    endtask

    task automatic test_random;
        logic [62:0] q[$];
        logic [30:0] t[3];
        int          ord[3];
        int          cyc;
        int          j;
        int          tmp;
        logic [62:0] exp_v;
        logic [62:0] seen;
        logic        xfer;
        logic        acc;
        cyc = 0;
        for (int p = 0; p < 10000 && cyc < BUDGET; p++) begin
            t[0] = 31'($urandom);
            t[1] = 31'($urandom);
            t[2] = 31'($urandom);
            q.push_back({32'b0, t[0]} ^ ({32'b0, t[1]} << 16)
                        ^ ({32'b0, t[2]} << 32));
            ord[0] = 0; ord[1] = 1; ord[2] = 2;
            for (int i = 2; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            for (int k = 0; k < 3; k++) begin
                acc = 1'b0;
                while (!acc && cyc < BUDGET) begin
                    pv32  = ($urandom_range(0, 7) != 0);
                    sel32 = 2'(ord[k]);
                    dat32 = t[ord[k]];
                    or32  = ($urandom_range(0, 7) != 0);
                    #1;
                    acc  = pv32 && pr32;
                    xfer = ov32 && or32;
                    seen = od32;
                    step();
                    cyc++;
                    if (xfer) begin
                        vectors++;
                        if (q.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_extra: got %h want none",
                                     seen);
                        end else begin
                            exp_v = q.pop_front();
                            if (seen !== exp_v) begin
                                miscompares++;
                                $display("FAIL rand_data: got %h want %h",
                                         seen, exp_v);
                            end
                        end
                    end
                end
            end
        end
        pv32 = 1'b0;
        or32 = 1'b1;
        while (q.size() != 0 && cyc < BUDGET) begin
            #1;
            xfer = ov32 && or32;
            seen = od32;
            step();
            cyc++;
            if (xfer) begin
                exp_v = q.pop_front();
                vectors++;
                if (seen !== exp_v) begin
                    miscompares++;
                    $display("FAIL rand_data: got %h want %h", seen, exp_v);
                end
            end
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_timeout: got %0d pending want 0", q.size());
        end
        step();
    endtask

    task automatic test_async_reset;
        or32 = 1'b0;
        beat32(2'd0, 31'h1);
        beat32(2'd1, 31'h2);
        beat32(2'd2, 31'h3);
        beat32(2'd0, 31'h5);
        beat32(2'd3, 31'h0);
        vectors++;
        if (ov32 !== 1'b1 || err32 !== 1'b1) begin
            miscompares++;
            $display("FAIL ares_pre: got v=%b e=%b want 1 1", ov32, err32);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ov32 !== 1'b0 || od32 !== 63'h0 || err32 !== 1'b0
            || pr32 !== 1'b1) begin
            miscompares++;
            $display("FAIL ares_clear: got v=%b d=%h e=%b r=%b want 0 0 0 1",
                     ov32, od32, err32, pr32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (pr32 !== 1'b1) begin
            miscompares++;
            $display("FAIL ares_ready: got %b want 1", pr32);
        end
        or32 = 1'b1;
        beat32(2'd0, 31'h7);
        beat32(2'd1, 31'h0);
        vectors++;
        if (ov32 !== 1'b0) begin
            miscompares++;
            $display("FAIL ares_partial_lost: got v=%b want 0", ov32);
        end
        beat32(2'd2, 31'h0);
        vectors++;
        if (ov32 !== 1'b1 || od32 !== 63'h7) begin
            miscompares++;
            $display("FAIL ares_result: got v=%b d=%h want 1 7", ov32, od32);
        end
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_duplicate();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
